// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the truth-table sequencer.
package truth_table_sequencer_pkg;

  localparam int unsigned DWELL_W = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TBL_W   = 16;

  localparam logic [TBL_W-1:0] GOLDEN_DEFAULT = 16'h77FF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic             pass;
    logic [IDX_W-1:0] fail_idx;
  } result_t;

  // Compare a captured table against the golden one; fail_idx is the lowest differing bit.
  function automatic result_t judge(input logic [TBL_W-1:0] tbl, input logic [TBL_W-1:0] gold);
    result_t          res;
    logic [TBL_W-1:0] diff;
    diff         = tbl ^ gold;
    res.pass     = (diff == '0);
    res.fail_idx = '0;
    for (int i = TBL_W - 1; i >= 0; i--) begin
      if (diff[i]) res.fail_idx = IDX_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// Dwell counter: counts cycles a vector is held, flags the terminal count.
module dwell_timer
  import truth_table_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_term,
  output logic               o_tc_c
);

  logic [DWELL_W-1:0] r_cnt;

  assign o_tc_c = (r_cnt == i_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc_c ? '0 : r_cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input function through all 16 vectors, captures its truth table and checks it.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned      DWELL  = 4,
  parameter logic [TBL_W-1:0] GOLDEN = GOLDEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             fn_in,
  output logic [IDX_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [TBL_W-1:0] table_q,
  output logic [IDX_W-1:0] fail_idx
);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [TBL_W-1:0] r_table;
  logic [IDX_W-1:0] r_fail_idx;

  logic [1:0]       w_nxt_state;
  logic [IDX_W-1:0] w_nxt_index;
  logic [IDX_W-1:0] w_nxt_vec;
  logic             w_nxt_pass;
  logic [TBL_W-1:0] w_nxt_table;
  logic [IDX_W-1:0] w_nxt_fail_idx;
  logic             w_tc;
  logic             w_load;
  logic             w_en;
  result_t          w_result;

  // Counter stays cleared outside RUN so every sweep starts from zero.
  assign w_load = (r_state != ST_RUN);
  assign w_en   = (r_state == ST_RUN) && !abort;

  dwell_timer u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_en   (w_en),
    .i_term (DWELL_W'(DWELL - 1)),
    .o_tc_c (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_vec      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_table    <= '0;
      r_fail_idx <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_index    <= w_nxt_index;
      r_vec      <= w_nxt_vec;
      r_busy     <= (w_nxt_state == ST_RUN);
      r_done     <= (w_nxt_state == ST_DONE);
      r_pass     <= w_nxt_pass;
      r_table    <= w_nxt_table;
      r_fail_idx <= w_nxt_fail_idx;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_index    = r_index;
    w_nxt_vec      = '0;
    w_nxt_pass     = r_pass;
    w_nxt_table    = r_table;
    w_nxt_fail_idx = r_fail_idx;
    w_result       = '0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_nxt_state = ST_RUN;
          w_nxt_index = '0;
          w_nxt_table = '0;
          w_nxt_pass  = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_nxt_state = ST_IDLE;
          w_nxt_pass  = 1'b0;
        end else begin
          w_nxt_vec = r_index;
          if (w_tc) begin
            w_nxt_table[r_index] = fn_in;
            // The final sample is judged together with the rest of the table.
            if (r_index == IDX_W'(TBL_W - 1)) begin
              w_result       = judge(w_nxt_table, GOLDEN);
              w_nxt_state    = ST_DONE;
              w_nxt_vec      = '0;
              w_nxt_pass     = w_result.pass;
              w_nxt_fail_idx = w_result.fail_idx;
            end else begin
              w_nxt_index = r_index + IDX_W'(1);
              w_nxt_vec   = r_index + IDX_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  assign vec      = r_vec;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign table_q  = r_table;
  assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a DWELL=4 and a DWELL=1 instance driven by a selectable function source.
module tb_truth_table_sequencer;

  localparam logic [15:0] GOLD = 16'h77FF;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] tbl;
    logic [15:0] exp_t;
    logic        exp_p;
    logic [3:0]  exp_i;
  } vec_rec_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       start_v;
  logic [1:0]       abort_v;
  logic [1:0]       fn_v;
  logic [1:0][3:0]  vec_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;
  logic [1:0]       pass_v;
  logic [1:0][15:0] tq_v;
  logic [1:0][3:0]  fi_v;
  logic [1:0][1:0]  mode_v;
  logic [1:0][15:0] tbl_v;

  int n_cmp = 0;
  int n_bad = 0;

  truth_table_sequencer #(.DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .fn_in(fn_v[0]),
    .vec(vec_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .table_q(tq_v[0]), .fail_idx(fi_v[0])
  );

  truth_table_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .fn_in(fn_v[1]),
    .vec(vec_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .table_q(tq_v[1]), .fail_idx(fi_v[1])
  );

  // Mode 0 is the real function f = ~(d & b & a); 1 is stuck-at-1; 2 replays an arbitrary table.
  function automatic logic fsrc(input logic [1:0] m, input logic [15:0] t, input logic [3:0] v);
    case (m)
      2'd0:    return ~(v[3] & v[1] & v[0]);
      2'd1:    return 1'b1;
      default: return t[v];
    endcase
  endfunction

  always_comb begin
    fn_v[0] = fsrc(mode_v[0], tbl_v[0], vec_v[0]);
    fn_v[1] = fsrc(mode_v[1], tbl_v[1], vec_v[1]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_pass(input logic [15:0] t);
    return t == GOLD;
  endfunction

  // Lowest differing index: isolate the lowest set bit of the difference, then count bits below it.
  function automatic logic [3:0] ref_idx(input logic [15:0] t);
    logic [15:0] d;
    logic [15:0] iso;
    d = t ^ GOLD;
    if (d == 16'h0) return 4'd0;
    iso = d & (~d + 16'd1);
    return 4'($countones(iso - 16'd1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One sweep; optional re-start, abort or reset at a given cycle after the start edge (-1 = none).
  task automatic sweep(input int sel, input int dw, input logic [1:0] md, input logic [15:0] tt,
                       input logic [15:0] exp_t, input logic exp_p, input logic [3:0] exp_i,
                       input int restart_at, input int abort_at, input int rst_at, input string tag);
    int          ndone, dcyc, nbusy, vbad, stop_at, nsamp;
    logic [15:0] cap_t, want;
    logic        cap_p;
    logic [3:0]  cap_i, want_v;
    mode_v[sel] = md;
    tbl_v[sel]  = tt;
    ndone = 0; dcyc = -1; nbusy = 0; vbad = 0;
    cap_t = '0; cap_p = 1'b0; cap_i = '0;
    stop_at = (abort_at >= 0) ? abort_at : rst_at;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 16 * dw + 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      start_v[sel] = 1'b0;
      abort_v[sel] = 1'b0;
      if (busy_v[sel]) nbusy++;
      if (done_v[sel]) begin
        ndone++; dcyc = c;
        cap_t = tq_v[sel]; cap_p = pass_v[sel]; cap_i = fi_v[sel];
      end
      want_v = ((c < 16 * dw) && (stop_at < 0 || c <= stop_at)) ? 4'(c / dw) : 4'd0;
      if (vec_v[sel] !== want_v) vbad++;
      if (c == restart_at) start_v[sel] = 1'b1;
      if (c == abort_at) abort_v[sel] = 1'b1;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_outs"}, 32'({vec_v[sel], busy_v[sel], done_v[sel], pass_v[sel], tq_v[sel], fi_v[sel]}), 32'd0);
        #2;
        rst_n = 1'b1;
      end
    end
    chk({tag, "_vec_seq_errs"}, 32'(vbad), 32'd0);
    if (stop_at >= 0) begin
      nsamp = (abort_at >= 0) ? abort_at / dw : 0;
      want  = exp_t & 16'((32'd1 << nsamp) - 32'd1);
      chk({tag, "_no_done"}, 32'(ndone), 32'd0);
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(stop_at + 1));
      chk({tag, "_partial_table"}, 32'(tq_v[sel]), 32'(want));
      chk({tag, "_pass_low"}, 32'(pass_v[sel]), 32'd0);
    end else begin
      chk({tag, "_done_count"}, 32'(ndone), 32'd1);
      chk({tag, "_done_cycle"}, 32'(dcyc), 32'(16 * dw));
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(16 * dw));
      chk({tag, "_table"}, 32'(cap_t), 32'(exp_t));
      chk({tag, "_pass"}, 32'(cap_p), 32'(exp_p));
      chk({tag, "_fail_idx"}, 32'(cap_i), 32'(exp_i));
      chk({tag, "_pass_held"}, 32'(pass_v[sel]), 32'(exp_p));
    end
  endtask

  vec_rec_t vt[6];

  initial begin
    logic [15:0] rt;
    int          sel, dw, ab;
    vt[0] = '{mode: 2'd0, tbl: 16'h0000, exp_t: 16'h77FF, exp_p: 1'b1, exp_i: 4'd0};
    vt[1] = '{mode: 2'd1, tbl: 16'h0000, exp_t: 16'hFFFF, exp_p: 1'b0, exp_i: 4'd11};
    vt[2] = '{mode: 2'd2, tbl: 16'h0000, exp_t: 16'h0000, exp_p: 1'b0, exp_i: 4'd0};
    vt[3] = '{mode: 2'd2, tbl: 16'h77FE, exp_t: 16'h77FE, exp_p: 1'b0, exp_i: 4'd0};
    vt[4] = '{mode: 2'd2, tbl: 16'hF7FF, exp_t: 16'hF7FF, exp_p: 1'b0, exp_i: 4'd15};
    vt[5] = '{mode: 2'd2, tbl: 16'h7FFF, exp_t: 16'h7FFF, exp_p: 1'b0, exp_i: 4'd11};

    rst_n = 1'b0; start_v = '0; abort_v = '0; mode_v = '0; tbl_v = '0;
    #3;
    chk("reset_outs_dwell4", 32'({vec_v[0], busy_v[0], done_v[0], pass_v[0], tq_v[0], fi_v[0]}), 32'd0);
    chk("reset_outs_dwell1", 32'({vec_v[1], busy_v[1], done_v[1], pass_v[1], tq_v[1], fi_v[1]}), 32'd0);
    #9;
    rst_n = 1'b1;

    // First entry starts straight after reset release: accepted on the first rising edge.
    for (int i = 0; i < 6; i++) begin
      sweep(0, 4, vt[i].mode, vt[i].tbl, vt[i].exp_t, vt[i].exp_p, vt[i].exp_i, -1, -1, -1,
            $sformatf("vt%0d", i));
    end

    sweep(0, 4, 2'd0, 16'h0, GOLD, 1'b1, 4'd0, 10, -1, -1, "restart10");
    sweep(0, 4, 2'd0, 16'h0, GOLD, 1'b1, 4'd0, -1, 20, -1, "abort20");
    chk("abort20_table_exact", 32'(tq_v[0]), 32'h001F);
    sweep(0, 4, 2'd0, 16'h0, GOLD, 1'b1, 4'd0, -1, -1, 30, "rst30");
    sweep(0, 4, 2'd0, 16'h0, GOLD, 1'b1, 4'd0, -1, -1, -1, "after_rst");

    // DWELL=1: start together with abort must not leave IDLE.
    mode_v[1] = 2'd0;
    start_v[1] = 1'b1; abort_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0; abort_v[1] = 1'b0;
    chk("d1_start_abort_busy", 32'(busy_v[1]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("d1_start_abort_idle", 32'({busy_v[1], done_v[1], vec_v[1]}), 32'd0);
    sweep(1, 1, 2'd0, 16'h0, GOLD, 1'b1, 4'd0, -1, -1, -1, "d1_full");

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      dw  = (sel == 0) ? 4 : 1;
      rt  = 16'($urandom);
      if (i == 0) rt = GOLD;
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16 * dw - 1)) : -1;
      sweep(sel, dw, 2'd2, rt, rt, ref_pass(rt), ref_idx(rt), -1, ab, -1, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning clock cycles each input vector is held (legal range 1..255).
REQ-002 SHALL have parameter GOLDEN, default 16'h77FF, meaning the expected 16-entry truth table of the 4-input logic function; bit i corresponds to vec = i.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port abort  input  1  cancel a sweep in progress.
REQ-007 SHALL have port fn_in  input  1  output f of the logic function under test.
REQ-008 SHALL have port vec  output  4  drive to the function inputs {d,c,b,a}, a = bit 0.
REQ-009 SHALL have port busy  output  1  high while a sweep is running.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port pass  output  1  captured table equals GOLDEN; valid while done is high and held until the next start.
REQ-012 SHALL have port table_q  output  16  captured truth table.
REQ-013 SHALL have port fail_idx  output  4  lowest index where table_q differs from GOLDEN; 0 when pass = 1.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN, and DONE.
REQ-015 SHALL use these transitions: IDLE->RUN on start=1 and abort=0; RUN->DONE after index 15 is sampled; RUN->IDLE on abort=1; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL, on the edge that accepts start, set index to 0, clear the dwell counter, clear table_q to 0, and clear pass.
REQ-017 SHALL, in RUN, drive vec = index and hold it stable for exactly DWELL cycles.
REQ-018 SHALL, on the edge where the dwell counter equals DWELL-1, write fn_in into table_q[index], reset the counter, and increment index.
REQ-019 SHALL, after the final sample (index 15), transition to DONE, not wrap the index, and take no seventeenth sample.
REQ-020 SHALL raise done for exactly one cycle, 16*DWELL cycles after the start-accepting edge.
REQ-021 SHALL update pass and fail_idx on the same edge that raises done.
REQ-022 SHALL hold busy = 1 in RUN only.
REQ-023 SHALL ignore start while in RUN or DONE.
REQ-024 SHALL give abort priority over start in the same cycle.
REQ-025 SHALL, on abort in RUN, go to IDLE on the next edge with done = 0 and pass = 0, and retain the partial table_q.
REQ-026 SHALL drive vec = 0 in IDLE and DONE.
REQ-027 SHALL, with DWELL = 1, sample every cycle; a full sweep then takes 16 cycles.

Reset
REQ-028 SHALL, on rst_n = 0, asynchronously force state to IDLE, vec = 0, busy = 0, done = 0, pass = 0, table_q = 0, fail_idx = 0, and clear index and dwell counter.
REQ-029 SHALL, on reset asserted mid-sweep, abandon the sweep and produce no done pulse.
REQ-030 SHALL, after reset release, accept start on the first rising edge.

Structure
REQ-031 SHALL place the FSM state encoding, the GOLDEN default (16'h77FF), and the DWELL width constant in a shared package.
REQ-032 SHALL instantiate the dwell timer (counter, load, and terminal-count flag) as sub-module dwell_timer.
REQ-033 SHALL use a testbench that instantiates the existing 4-input logic function with vec and fn_in wired to it.

Verification
REQ-034 SHALL check: reset, then start with DWELL = 4 -> busy for 64 cycles, done pulse at cycle 64, table_q = 16'h77FF, pass = 1, fail_idx = 0.
REQ-035 SHALL check: fn_in forced to 1 throughout -> table_q = 16'hFFFF, pass = 0, fail_idx = 11.
REQ-036 SHALL check: abort asserted at cycle 20 (DWELL = 4) -> IDLE next cycle, no done, table_q[4:0] = 5'h1F and upper bits 0.
REQ-037 SHALL check: start re-asserted at cycle 10 of a sweep -> ignored, single done at cycle 64.
REQ-038 SHALL check: rst_n pulled low at cycle 30 -> all outputs 0 immediately, no done; a new start afterwards completes normally.
REQ-039 SHALL check: DWELL = 1 with start and abort in the same cycle -> stays IDLE; start alone -> done at cycle 16, pass = 1.
